// File: rtl/noc_xbar_pkg.sv
// Shared NoC crossbar definitions: flit types, per-output FSM states and flit-type extraction.
// The route computation uses the same flit-type constants.
package noc_xbar_pkg;

    localparam int MAX_DATA_W = 256;

    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b10;
    localparam logic [1:0] FLIT_TAIL   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The type field is the top two bits of a data_w-bit flit (zero-extended into flit).
    function automatic logic [1:0] flit_type(input logic [MAX_DATA_W-1:0] flit, input int data_w);
        logic [MAX_DATA_W-1:0] shifted;
        shifted = flit >> (data_w - 2);
        return shifted[1:0];
    endfunction

    function automatic logic is_start(input logic [1:0] ftype);
        return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/noc_xbar_if.sv
// Crossbar channel bundle: input flit channels, per-output selects and output flit channels.
interface noc_xbar_if #(
    parameter int NPORTS = 5,
    parameter int DATA_W = 32
);
    logic [NPORTS*DATA_W-1:0] in_data;
    logic [NPORTS-1:0]        in_valid;
    logic [NPORTS-1:0]        in_ready;
    logic [NPORTS*NPORTS-1:0] sel;
    logic [NPORTS*DATA_W-1:0] out_data;
    logic [NPORTS-1:0]        out_valid;
    logic [NPORTS-1:0]        out_ready;
    logic [NPORTS-1:0]        sel_err;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/noc_xbar_out_port.sv
// One crossbar output: select check, head-to-tail lock FSM, input mux and output register.
// NOC_XBAR_UTURN_EN defined allows this output to select its own input index (loopback).
module noc_xbar_out_port
    import noc_xbar_pkg::*;
#(
    parameter int NPORTS  = 5,
    parameter int DATA_W  = 32,
    parameter int PORT_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS*DATA_W-1:0] in_data,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS-1:0]        in_ready,
    input  logic [NPORTS-1:0]        sel,
    input  logic                     out_ready,
    output logic [NPORTS-1:0]        conn,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     sel_err
);
    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  src_reg, src_next, sel_idx, cur_idx;
    logic [DATA_W-1:0] out_data_reg, mux_data;
    logic              out_valid_reg, sel_err_reg, sel_err_next;
    logic [1:0]        in_type [NPORTS];
    logic [DATA_W-1:0] masked [NPORTS];
    logic [1:0]        cur_type;
    logic              multi_hot, uturn_bad, sel_illegal, xfer;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
            assign in_type[gi] = flit_type(MAX_DATA_W'(in_data[gi*DATA_W +: DATA_W]), DATA_W);
            assign masked[gi]  = conn[gi] ? in_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

`ifdef NOC_XBAR_UTURN_EN
    assign uturn_bad = 1'b0;
`else
    assign uturn_bad = sel[PORT_ID];
`endif

    assign multi_hot   = |(sel & (sel - NPORTS'(1)));
    assign sel_illegal = multi_hot | uturn_bad;
    assign cur_idx     = (state_reg == ST_BUSY) ? src_reg : sel_idx;
    assign cur_type    = in_type[cur_idx];
    assign xfer        = |(conn & in_valid & in_ready);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            mux_data = mux_data | masked[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            src_reg   <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
        end
    end

    // FSM: next state; a HEAD locks the output to its source until the matching TAIL leaves
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        case (state_reg)
            ST_IDLE: if (xfer && cur_type == FLIT_HEAD) begin
                state_next = ST_BUSY;
                src_next   = sel_idx;
            end
            ST_BUSY: if (xfer && cur_type == FLIT_TAIL) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. An idle output only connects to a legal source holding a packet start.
    always_comb begin
        conn         = '0;
        sel_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sel_illegal) begin
                    sel_err_next = 1'b1;
                end else if (sel != '0 && in_valid[sel_idx]) begin
                    if (is_start(cur_type)) conn = sel;
                    else                    sel_err_next = 1'b1;
                end
            end
            ST_BUSY: begin
                conn[src_reg] = 1'b1;
                if (xfer && is_start(cur_type)) sel_err_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            sel_err_reg <= sel_err_next;
            if (xfer) begin
                out_data_reg  <= mux_data;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: rtl/noc_xbar_param.sv
// NPORTS x NPORTS flit crossbar with per-output packet locking and one register stage per output.
// NOC_XBAR_UTURN_EN (optional) enables loopback selects in every output port.
module noc_xbar_param
    import noc_xbar_pkg::*;
#(
    parameter int NPORTS = 5,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    noc_xbar_if.slave   bus
);
    logic [NPORTS-1:0] conn [NPORTS];
    logic [NPORTS-1:0] col [NPORTS];
    logic [DATA_W-1:0] out_data_arr [NPORTS];
    logic [NPORTS-1:0] out_valid_vec, sel_err_vec, can_accept, in_ready;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_out
            noc_xbar_out_port #(
                .NPORTS (NPORTS),
                .DATA_W (DATA_W),
                .PORT_ID(gi)
            ) u_port (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_data  (bus.in_data),
                .in_valid (bus.in_valid),
                .in_ready (in_ready),
                .sel      (bus.sel[gi*NPORTS +: NPORTS]),
                .out_ready(bus.out_ready[gi]),
                .conn     (conn[gi]),
                .out_data (out_data_arr[gi]),
                .out_valid(out_valid_vec[gi]),
                .sel_err  (sel_err_vec[gi])
            );
            assign can_accept[gi] = !out_valid_vec[gi] | bus.out_ready[gi];
            assign bus.out_data[gi*DATA_W +: DATA_W] = out_data_arr[gi];
        end

        // col[i] lists the outputs connected to input i; all of them must accept (multicast is all-or-none)
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
            for (genvar go = 0; go < NPORTS; go++) begin : g_col
                assign col[gi][go] = conn[go][gi];
            end
            assign in_ready[gi] = rst_n & (|col[gi]) & (&(~col[gi] | can_accept));
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_vec;
    assign bus.sel_err   = sel_err_vec;

endmodule
